// File: rtl/layernorm_stats_engine_if.sv
// rtl/layernorm_stats_engine_if.sv - beat input stream and result handshake for the layernorm stats engine
interface layernorm_stats_engine_if #(
  parameter int NUM_PE     = 8,
  parameter int DATA_WIDTH = 24
);
  localparam int VAR_WIDTH = 2 * DATA_WIDTH;

  logic [NUM_PE*DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         abort;
  logic [DATA_WIDTH-1:0]        mean_out;
  logic [VAR_WIDTH-1:0]         var_out;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;

  modport master (
    output in_data, in_valid, abort, out_ready,
    input  in_ready, mean_out, var_out, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, abort, out_ready,
    output in_ready, mean_out, var_out, out_valid, busy
  );
endinterface

// File: rtl/layernorm_stats_engine.sv
// rtl/layernorm_stats_engine.sv - streaming mean/variance over a D_MODEL vector fed NUM_PE lanes per beat
module layernorm_stats_engine #(
  parameter int D_MODEL    = 128,
  parameter int NUM_PE     = 8,
  parameter int DATA_WIDTH = 24
) (
  input logic                      clk,
  input logic                      rst_n,
  layernorm_stats_engine_if.slave  bus
);
  localparam int L         = $clog2(D_MODEL);
  localparam int BEATS     = D_MODEL / NUM_PE;
  localparam int VAR_WIDTH = 2 * DATA_WIDTH;
  localparam int SUM_W     = DATA_WIDTH + L;
  localparam int SQ2       = 2 * DATA_WIDTH;
  localparam int SQ_W      = 2 * DATA_WIDTH + L;
  localparam int CNT_W     = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [SQ_W-1:0]           sumsq_q, sumsq_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     mean_q, mean_d;
  logic [VAR_WIDTH-1:0]      var_q, var_d;

  logic                      in_ready, busy, out_valid, accept, last_beat;
  logic signed [DATA_WIDTH-1:0] lane;
  logic signed [SQ2-1:0]     lane_sq;
  logic signed [SUM_W-1:0]   beat_sum;
  logic [SQ_W-1:0]           beat_sq;
  logic signed [DATA_WIDTH-1:0] mean_c;
  logic signed [SQ2-1:0]     mean_sq;
  logic signed [SQ_W:0]      diff;
  logic [VAR_WIDTH-1:0]      var_c;

  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    lane     = '0;
    lane_sq  = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      lane     = $signed(bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]);
      lane_sq  = SQ2'(lane) * SQ2'(lane);
      beat_sum = beat_sum + SUM_W'(lane);
      beat_sq  = beat_sq + SQ_W'($unsigned(lane_sq));
    end
  end

  // Floor mean via arithmetic shift; a negative variance only comes from flooring and is clamped.
  always_comb begin
    mean_c  = DATA_WIDTH'(sum_q >>> L);
    mean_sq = SQ2'(mean_c) * SQ2'(mean_c);
    diff    = signed'({1'b0, sumsq_q >> L}) - signed'((SQ_W+1)'($unsigned(mean_sq)));
    var_c   = diff[SQ_W] ? '0 : VAR_WIDTH'(diff);
  end

  assign accept    = bus.in_valid && in_ready && !bus.abort;
  assign last_beat = (state_q == IDLE) ? (CNT_W'(1) == CNT_W'(BEATS))
                                       : (cnt_q + CNT_W'(1) == CNT_W'(BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      sumsq_q <= '0;
      cnt_q   <= '0;
      mean_q  <= '0;
      var_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q   <= cnt_d;
      mean_q  <= mean_d;
      var_q   <= var_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = last_beat ? FINAL : ACCUM;
        ACCUM:   if (accept && last_beat) state_d = FINAL;
        FINAL:   state_d = OUT;
        OUT:     if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE || state_q == ACCUM);
    busy      = (state_q != IDLE);
    out_valid = (state_q == OUT);
  end

  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    cnt_d   = cnt_q;
    mean_d  = mean_q;
    var_d   = var_q;
    if (bus.abort) begin
      sum_d   = '0;
      sumsq_d = '0;
      cnt_d   = '0;
    end else if (accept && state_q == IDLE) begin
      sum_d   = beat_sum;
      sumsq_d = beat_sq;
      cnt_d   = CNT_W'(1);
    end else if (accept) begin
      sum_d   = sum_q + beat_sum;
      sumsq_d = sumsq_q + beat_sq;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (state_q == FINAL) begin
      mean_d = mean_c;
      var_d  = var_c;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.mean_out  = mean_q;
  assign bus.var_out   = var_q;
endmodule

// File: tb/tb_layernorm_stats_engine.sv
// tb/tb_layernorm_stats_engine.sv - randomized self-checking bench for layernorm_stats_engine
module tb_layernorm_stats_engine;
  localparam int D  = 16;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int LB = $clog2(D);

  typedef int vec_t [D];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  layernorm_stats_engine_if #(.NUM_PE(NP), .DATA_WIDTH(DW)) ifc ();

  layernorm_stats_engine #(.D_MODEL(D), .NUM_PE(NP), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] mean_o();
    return $signed(ifc.mean_out);
  endfunction

  function automatic logic signed [63:0] var_o();
    return {32'b0, ifc.var_out};
  endfunction

  // Reference: plain integer statistics over the whole vector.
  function automatic void model(input vec_t e, output longint m, output longint v);
    longint s = 0;
    longint q = 0;
    for (int i = 0; i < D; i++) begin
      s += e[i];
      q += longint'(e[i]) * e[i];
    end
    m = s >>> LB;
    v = (q >> LB) - m * m;
    if (v < 0) v = 0;
  endfunction

  function automatic logic [NP*DW-1:0] pack(input vec_t e, input int b);
    logic [NP*DW-1:0] p;
    int x;
    for (int k = 0; k < NP; k++) begin
      x = e[b*NP + k];
      p[k*DW +: DW] = x[DW-1:0];
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input vec_t e, input int first, input int n, input bit bubbles);
    for (int b = first; b < first + n; b++) begin
      if (bubbles) begin
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = pack(e, b);
      tick();
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_vector(input string tag, input vec_t e, input bit bubbles, input int hold,
                            input longint em, input longint ev);
    ifc.out_ready = (hold == 0);
    send_beats(e, 0, D / NP, bubbles);
    check({tag, ".final_ov"}, ifc.out_valid, 0);
    check({tag, ".final_rdy"}, ifc.in_ready, 0);
    tick();
    check({tag, ".ov"}, ifc.out_valid, 1);
    check({tag, ".mean"}, mean_o(), em);
    check({tag, ".var"}, var_o(), ev);
    for (int i = 0; i < hold; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = {$urandom, $urandom};
      tick();
      check({tag, ".hold_ov"}, ifc.out_valid, 1);
      check({tag, ".hold_rdy"}, ifc.in_ready, 0);
      check({tag, ".hold_mean"}, mean_o(), em);
      check({tag, ".hold_var"}, var_o(), ev);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    check({tag, ".done_ov"}, ifc.out_valid, 0);
    check({tag, ".done_rdy"}, ifc.in_ready, 1);
    check({tag, ".done_busy"}, ifc.busy, 0);
    check({tag, ".keep_mean"}, mean_o(), em);
  endtask

  initial begin
    vec_t   e;
    longint em, ev;

    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.abort     = 1'b0;
    ifc.out_ready = 1'b0;
    #1;
    check("rst.ov", ifc.out_valid, 0);
    check("rst.busy", ifc.busy, 0);
    check("rst.mean", mean_o(), 0);
    check("rst.var", var_o(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rst.rdy", ifc.in_ready, 1);

    for (int i = 0; i < D; i++) e[i] = i;
    run_vector("ramp", e, 1'b0, 0, 7, 28);

    for (int i = 0; i < D; i++) e[i] = (i % 2 == 0) ? 3 : -3;
    run_vector("alt3", e, 1'b1, 0, 0, 9);

    for (int i = 0; i < D; i++) e[i] = 0;
    e[9] = -1;
    run_vector("neg1", e, 1'b0, 0, -1, 0);

    for (int i = 0; i < D; i++) e[i] = 5;
    run_vector("hold5", e, 1'b0, 5, 5, 0);

    for (int i = 0; i < D; i++) e[i] = int'($urandom_range(0, 65535)) - 32768;
    send_beats(e, 0, 2, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.abort    = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    ifc.abort    = 1'b0;
    check("abort.busy", ifc.busy, 0);
    check("abort.rdy", ifc.in_ready, 1);
    for (int i = 0; i < D; i++) e[i] = -32768;
    run_vector("minval", e, 1'b0, 0, -32768, 0);

    for (int i = 0; i < D; i++) e[i] = 1000 * i;
    send_beats(e, 0, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.mean", mean_o(), 0);
    check("midrst.var", var_o(), 0);
    check("midrst.ov", ifc.out_valid, 0);
    check("midrst.busy", ifc.busy, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst.rdy", ifc.in_ready, 1);
    for (int i = 0; i < D; i++) e[i] = 7;
    run_vector("all7", e, 1'b0, 0, 7, 0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < D; i++) begin
        case ($urandom_range(0, 3))
          0:       e[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
          1:       e[i] = int'($urandom_range(0, 40)) - 20;
          default: e[i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      model(e, em, ev);
      run_vector($sformatf("rnd%0d", t), e, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), em, ev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
